uart_tx_serial: RTL and testbench
=================================

// Module: uart_tx_serial
// PURPOSE
//  UART transmit serializer; the transmit end of the team's 11-bit UART frame.
//  Accepts one byte per valid/ready handshake and builds the frame {stop,parity,data[7:0],start}.
//  Shifts the frame out LSB-first on a single line, holding each bit CLKS_PER_BIT clocks.
//  Also presents the assembled 11-bit frame in parallel for the existing frame-level receiver.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per serial bit; legal >= 2; bit-timer width $clog2(CLKS_PER_BIT)
// PORTS
//  clk       in   1   single clock; all logic on posedge clk
//  reset     in   1   synchronous, active-high reset
//  tx_data   in   8   byte to send; sampled only on the accept cycle
//  tx_valid  in   1   byte available
//  tx_ready  out  1   high only in IDLE; accept = tx_valid && tx_ready
//  tx        out  1   serial line, idle high, registered
//  tx_busy   out  1   high from the cycle after accept until the end of the stop bit
//  tx_done   out  1   one-cycle pulse on the last clock of the stop bit
//  tx_frame  out  11  [0]=start(0) [8:1]=data [9]=even parity(^data) [10]=stop(1)
// BEHAVIOUR
//  Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, tx_frame=11'h7FF, FSM=IDLE.
//  Reset mid-frame aborts the frame; tx is 1 at the first edge after reset.
//  FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE: on accept, latch tx_frame and the shift register; go to START next cycle.
//   START: tx=0 for CLKS_PER_BIT clocks.
//   DATA: 8 bits, data[0] first; bit index 0..7 advances on bit-timer wrap; exit at index 7 wrap.
//   PARITY: tx=^data for CLKS_PER_BIT clocks.
//   STOP: tx=1 for CLKS_PER_BIT clocks; tx_done on the last clock; then IDLE.
//  Bit timer: counts 0..CLKS_PER_BIT-1, clears on every state change; no drift across bits.
//  Latency: accept on edge N -> tx=0 from edge N+1. A frame occupies 11*CLKS_PER_BIT clocks.
//  tx_valid during busy is ignored; tx_data is not resampled mid-frame.
//  Back-to-back: with tx_valid held high, the next accept occurs in the IDLE cycle after tx_done.
//   The line therefore stays high CLKS_PER_BIT+1 clocks between frames.
//  tx_frame holds its value until the next accept.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state present; 11-bit serial frame as above.
//  UART_TX_PARITY_EN undefined: DATA -> STOP directly; 10 bits on the line (10*CLKS_PER_BIT clocks).
//   tx_frame[9] still carries ^data in both builds, so the parallel frame format is unchanged.
// STRUCTURE
//  uart_pkg: state encoding (IDLE/START/DATA/PARITY/STOP, 3-bit)
//   plus frame index constants START_IDX=0, DATA_LSB=1, PAR_IDX=9, STOP_IDX=10.
//   Shared with the receiver.
//  Sub-module uart_baud_tick: bit timer with clear input and wrap pulse output.
//   Reused by the receiver oversampler.
// TESTING
//  1 Reset mid-DATA of a frame -> next cycle tx=1, tx_ready=1, tx_busy=0, tx_frame=11'h7FF.
//  2 CLKS_PER_BIT=4, send 8'hA5:
//    tx_frame=11'h54A; line = 0,1,0,1,0,0,1,0,1,0(par),1, each held 4 clks; tx_done at clk 44.
//  3 Send 8'h07 -> tx_frame=11'h60E, parity bit on the line =1.
//  4 tx_valid held, bytes 8'h00 then 8'hFF:
//    second start bit begins exactly 5 clks after the first stop bit starts (CLKS_PER_BIT=4).
//  5 Pulse tx_valid with 8'h3C mid-frame -> ignored, tx_frame unchanged, no extra frame.
//  6 Build without UART_TX_PARITY_EN, send 8'hA5 -> 10 bits on the line (40 clks).
//    tx_frame is still 11'h54A.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and frame bit positions.
// Used by both the transmit serializer and the frame-level receiver.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int START_IDX = 0;
  localparam int DATA_LSB  = 1;
  localparam int PAR_IDX   = 9;
  localparam int STOP_IDX  = 10;

  function automatic logic [10:0] build_frame(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1, wrap pulses on the last count.
// Shared with the receiver oversampler.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic wrap
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] cnt;

  assign wrap = (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || wrap)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_serial.sv
// UART transmit serializer, 11-bit frame {stop,parity,data,start}, LSB first.
// Define UART_TX_PARITY_EN to put the parity bit on the serial line.
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [10:0] tx_frame
);

  logic [2:0] state;
  logic [2:0] state_n;
  logic [2:0] bit_idx;
  logic [2:0] idx_n;
  logic [7:0] fdata;
  logic       wrap;
  logic       clear;
  logic       accept;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign tx_done  = (state == STOP) && wrap;
  assign accept   = tx_valid && tx_ready;
  assign fdata    = tx_frame[DATA_LSB +: 8];

  // Timer restarts on every state change so bits never drift.
  assign clear = (state == IDLE) || (state_n != state);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .wrap (wrap)
  );

  always_comb begin
    state_n = state;
    idx_n   = 3'd0;
    unique case (state)
      IDLE:   if (accept) state_n = START;
      START:  if (wrap) state_n = DATA;
      DATA: begin
        idx_n = bit_idx + {2'b00, wrap};
        if (wrap && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
      PARITY: if (wrap) state_n = STOP;
      STOP:   if (wrap) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_idx  <= 3'd0;
      tx       <= 1'b1;
      tx_frame <= 11'h7FF;
    end else begin
      state   <= state_n;
      bit_idx <= idx_n;
      if (accept)
        tx_frame <= build_frame(tx_data);
      unique case (state_n)
        START:   tx <= 1'b0;
        DATA:    tx <= fdata[idx_n];
        PARITY:  tx <= tx_frame[PAR_IDX];
        STOP:    tx <= tx_frame[STOP_IDX];
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serial.sv
// Self-checking bench for uart_tx_serial, CLKS_PER_BIT=4.
// Line bits are scoreboarded; timing and frame checks are inline.
module tb_uart_tx_serial;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;
  logic [10:0] tx_frame;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [1:0] exp_q[$];

  uart_tx_serial #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_frame(tx_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every busy cycle pops one expected {tx_done, tx}.
  always @(negedge clk) begin
    if (!reset && tx_busy) begin
      logic [1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL line_extra: busy with tx=%0b done=%0b, required nothing queued",
                 tx, tx_done);
      end else begin
        e = exp_q.pop_front();
        if ({tx_done, tx} !== e) begin
          n_fail++;
          $display("FAIL line_bit @%0d: done,tx=%b required %b", cyc, {tx_done, tx}, e);
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] d);
    logic [10:0] f;
    f = {1'b1, ^d, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      if (NBITS == 10 && b == 9) continue;
      for (int k = 0; k < CPB; k++)
        exp_q.push_back({(b == 10 && k == CPB - 1), f[b]});
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = tx_ready;
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    @(posedge clk); #1;
    wait_ready(ok);
    if (!ok) return;
    tx_valid = 1'b1;
    tx_data  = d;
    push_frame(d);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (tx_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (tx_busy) n = -1;
  endtask

  task automatic test_reset;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        reset = 1'b0;
        send_byte(8'hA5, ok);
        repeat (3 * CPB) begin
          @(posedge clk); #1;
        end
        reset = 1'b1;
      end
      @(posedge clk); #1;
      exp_q.delete();
      n_checks++;
      if (tx !== 1'b1) begin
        n_fail++; $display("FAIL reset_tx p%0d: got %b required 1", pass, tx);
      end
      n_checks++;
      if (tx_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready p%0d: got %b required 1", pass, tx_ready);
      end
      n_checks++;
      if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy_done p%0d: got %b%b required 00", pass, tx_busy, tx_done);
      end
      n_checks++;
      if (tx_frame !== 11'h7FF) begin
        n_fail++; $display("FAIL reset_frame p%0d: got %h required 7ff", pass, tx_frame);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_frame_a5;
    bit ok;
    int n;
    send_byte(8'hA5, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL a5_accept: got timeout required accept");
    end
    n_checks++;
    if (tx_frame !== 11'h54A) begin
      n_fail++; $display("FAIL a5_frame: got %h required 54a", tx_frame);
    end
    n = 1;
    while (!tx_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n != NBITS * CPB) begin
      n_fail++; $display("FAIL a5_done_clk: got %0d required %0d", n, NBITS * CPB);
    end
    wait_idle(n);
    n_checks++;
    if (n < 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL a5_drain: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_parity_07;
    bit ok;
    int n;
    send_byte(8'h07, ok);
    n_checks++;
    if (tx_frame !== 11'h60E) begin
      n_fail++; $display("FAIL p07_frame: got %h required 60e", tx_frame);
    end
    repeat (37) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL p07_parity_line: got %b required 1", tx);
    end
    wait_idle(n);
    n_checks++;
    if (n < 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL p07_drain: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    int t_done;
    int t_start;
    logic prev_tx;
    t_done = -1;
    t_start = -1;
    @(posedge clk); #1;
    wait_ready(ok);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    push_frame(8'h00);
    push_frame(8'hFF);
    @(posedge clk); #1;
    tx_data = 8'hFF;
    n_checks++;
    if (tx_frame !== 11'h400) begin
      n_fail++; $display("FAIL b2b_frame0: got %h required 400", tx_frame);
    end
    prev_tx = tx;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (t_done < 0 && tx_done) t_done = cyc;
      if (t_done >= 0 && prev_tx && !tx) begin
        t_start = cyc;
        break;
      end
      prev_tx = tx;
    end
    tx_valid = 1'b0;
    n_checks++;
    if (t_start < 0 || t_start - (t_done - (CPB - 1)) != CPB + 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d required %0d", t_start - (t_done - (CPB - 1)), CPB + 1);
    end
    n_checks++;
    if (tx_frame !== 11'h5FE) begin
      n_fail++; $display("FAIL b2b_frame1: got %h required 5fe", tx_frame);
    end
    wait_idle(n);
    n_checks++;
    if (n < 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_ignore_busy;
    bit ok;
    int n;
    send_byte(8'h81, ok);
    repeat (10) begin
      @(posedge clk); #1;
    end
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    n_checks++;
    if (tx_frame !== 11'h502) begin
      n_fail++; $display("FAIL ign_frame: got %h required 502", tx_frame);
    end
    n_checks++;
    if (tx_busy !== 1'b1) begin
      n_fail++; $display("FAIL ign_busy: got %b required 1", tx_busy);
    end
    wait_idle(n);
    repeat (3 * CPB) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (n < 0 || tx_busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ign_no_extra: got busy=%b left=%0d required 0/0", tx_busy, exp_q.size());
    end
    n_checks++;
    if (tx_frame !== 11'h502) begin
      n_fail++; $display("FAIL ign_frame_hold: got %h required 502", tx_frame);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity_07();
    test_back_to_back();
    test_ignore_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
